// File: rtl/mips_bus_arbiter.sv
// Two-master Avalon-style bus arbiter for the MIPS memory bus (m0 = fetch, m1 = data/loader).
// Define ARB_ROUND_ROBIN_EN for round-robin tie-break; default build gives m0 fixed priority.
module mips_bus_arbiter #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m0_address,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [31:0] m0_writedata,
    input  logic [3:0]  m0_byteenable,
    output logic        m0_waitrequest,
    output logic [31:0] m0_readdata,
    output logic        m0_readdatavalid,
    input  logic [31:0] m1_address,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_writedata,
    input  logic [3:0]  m1_byteenable,
    output logic        m1_waitrequest,
    output logic [31:0] m1_readdata,
    output logic        m1_readdatavalid,
    output logic [31:0] s_address,
    output logic        s_read,
    output logic        s_write,
    output logic [31:0] s_writedata,
    output logic [3:0]  s_byteenable,
    input  logic        s_waitrequest,
    input  logic [31:0] s_readdata,
    output logic [1:0]  grant,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        RDATA = 2'd2
    } state_t;

    state_t      state;
    logic [2:0]  lat_cnt;
    logic [31:0] m0_rdata_q;
    logic [31:0] m1_rdata_q;

    logic        req0;
    logic        req1;
    logic        pick_m1;
    logic        own_active;
    logic        rd_done;
    logic        own_read;
    logic        own_write;
    logic [31:0] own_address;
    logic [31:0] own_writedata;
    logic [3:0]  own_byteenable;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_m1;
    assign pick_m1 = req1 & (~req0 | ~last_m1);
`else
    assign pick_m1 = req1 & ~req0;
`endif

    assign own_read       = grant[1] ? m1_read       : m0_read;
    assign own_write      = grant[1] ? m1_write      : m0_write;
    assign own_address    = grant[1] ? m1_address    : m0_address;
    assign own_writedata  = grant[1] ? m1_writedata  : m0_writedata;
    assign own_byteenable = grant[1] ? m1_byteenable : m0_byteenable;

    assign own_active = (state == OWN);
    assign busy       = (state != IDLE);

    // Slave side is a pure mux of the owner while in OWN; write wins a read+write collision.
    always_comb begin
        s_address    = '0;
        s_read       = 1'b0;
        s_write      = 1'b0;
        s_writedata  = '0;
        s_byteenable = '0;
        if (own_active) begin
            s_address    = own_address;
            s_read       = own_read & ~own_write;
            s_write      = own_write;
            s_writedata  = own_writedata;
            s_byteenable = own_byteenable;
        end
    end

    assign m0_waitrequest = ~(own_active & grant[0]) | s_waitrequest;
    assign m1_waitrequest = ~(own_active & grant[1]) | s_waitrequest;

    // Read data is passed straight through on the strobe cycle and held afterwards.
    assign rd_done          = (state == RDATA) && (lat_cnt == 3'd0);
    assign m0_readdatavalid = rd_done & grant[0];
    assign m1_readdatavalid = rd_done & grant[1];
    assign m0_readdata      = m0_readdatavalid ? s_readdata : m0_rdata_q;
    assign m1_readdata      = m1_readdatavalid ? s_readdata : m1_rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= 2'b00;
            lat_cnt    <= 3'd0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_m1    <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        grant <= pick_m1 ? 2'b10 : 2'b01;
                        state <= OWN;
`ifdef ARB_ROUND_ROBIN_EN
                        last_m1 <= pick_m1;
`endif
                    end
                end
                OWN: begin
                    if (own_write) begin
                        if (!s_waitrequest) begin
                            state <= IDLE;
                            grant <= 2'b00;
                        end
                    end else if (own_read) begin
                        if (!s_waitrequest) begin
                            state   <= RDATA;
                            lat_cnt <= 3'(READ_LATENCY - 1);
                        end
                    end else begin
                        // Owner withdrew before acceptance: abandon without a transfer.
                        state <= IDLE;
                        grant <= 2'b00;
                    end
                end
                RDATA: begin
                    if (lat_cnt == 3'd0) begin
                        if (grant[0]) m0_rdata_q <= s_readdata;
                        if (grant[1]) m1_rdata_q <= s_readdata;
                        state <= IDLE;
                        grant <= 2'b00;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Scoreboard bench for mips_bus_arbiter: expected read data and grant order are queued
// when stimulus is issued and retired as the DUT produces read strobes / acceptances.
module tb_mips_bus_arbiter;

    localparam int RL = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] m0_address = '0, m1_address = '0;
    logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
    logic [31:0] m0_writedata = '0, m1_writedata = '0;
    logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [31:0] s_address;
    logic        s_read, s_write;
    logic [31:0] s_writedata;
    logic [3:0]  s_byteenable;
    logic        s_waitrequest = 1'b0;
    logic [31:0] s_readdata;
    logic [1:0]  grant;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    logic [1:0]  exp_grant_q[$];

    always #5 clk = ~clk;

    mips_bus_arbiter #(.READ_LATENCY(RL)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .grant(grant), .busy(busy)
    );

    function automatic logic [31:0] slv_data(input logic [31:0] a);
        return (a == 32'hBFC0_0000) ? 32'h1234_5678 : (a ^ 32'hA5A5_A5A5);
    endfunction

    // Slave model: data valid exactly RL cycles after an accepted read.
    int          slv_cnt = 0;
    logic [31:0] slv_addr = '0;
    always @(posedge clk) begin
        if (s_read && !s_waitrequest) begin
            slv_cnt  <= RL;
            slv_addr <= s_address;
        end else if (slv_cnt != 0) begin
            slv_cnt <= slv_cnt - 1;
        end
    end
    assign s_readdata = (slv_cnt == 1) ? slv_data(slv_addr) : 32'hBAD0_BAD0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Retire read data against the scoreboard; any strobe without a queued entry is spurious.
    always @(negedge clk) begin
        if (m0_readdatavalid) begin
            if (exp_q0.size() == 0) chk("m0_spurious_rdv", 1, 0);
            else chk("m0_rdata", m0_readdata, exp_q0.pop_front());
        end
        if (m1_readdatavalid) begin
            if (exp_q1.size() == 0) chk("m1_spurious_rdv", 1, 0);
            else chk("m1_rdata", m1_readdata, exp_q1.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        // Reset state
        cyc(); cyc();
        mid();
        chk("rst_busy_grant", {busy, grant}, 3'b000);
        chk("rst_wait", {m0_waitrequest, m1_waitrequest}, 2'b11);
        chk("rst_slave", {s_read, s_write, s_address, s_writedata, s_byteenable}, '0);
        chk("rst_rdv", {m0_readdatavalid, m1_readdatavalid}, 2'b00);
        chk("rst_rdata", {m0_readdata, m1_readdata}, 64'h0);
        cyc(); reset = 1'b0;
        cyc();

        // m0 read, zero wait
        m0_read = 1'b1; m0_address = 32'hBFC0_0000;
        exp_q0.push_back(32'h1234_5678);
        mid();
        chk("rd_arb_cycle", {grant, m0_waitrequest}, 3'b001);
        cyc(); mid();
        chk("rd_own", {grant, s_read, s_write}, 4'b0110);
        chk("rd_addr", s_address, 32'hBFC0_0000);
        chk("rd_m0_wait", m0_waitrequest, 1'b0);
        chk("rd_m1_wait", m1_waitrequest, 1'b1);
        cyc(); m0_read = 1'b0; mid();
        chk("rd_rdata_busy", {busy, s_read, m0_waitrequest}, 3'b101);
        n = 2;
        while (!m0_readdatavalid && n < 12) begin
            cyc(); mid(); n++;
        end
        chk("rd_latency", n, 1 + RL);
        chk("rd_m1_quiet", {m1_readdatavalid, m1_readdata}, 33'h0);
        cyc(); mid();
        chk("rd_back_idle", {busy, grant, m0_readdatavalid}, 4'b0000);
        chk("rd_hold", m0_readdata, 32'h1234_5678);

        // m1 write with 3 wait cycles
        cyc();
        m1_write = 1'b1; m1_address = 32'hBFC0_0004;
        m1_writedata = 32'hDEAD_BEEF; m1_byteenable = 4'b0011; s_waitrequest = 1'b1;
        mid();
        chk("wr_arb_wait", m1_waitrequest, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            cyc();
            s_waitrequest = (c == 4) ? 1'b0 : 1'b1;
            mid();
            chk("wr_strobe", {grant, s_write, s_read}, 4'b1010);
            chk("wr_bus", {s_address, s_writedata}, {32'hBFC0_0004, 32'hDEAD_BEEF});
            chk("wr_be", s_byteenable, 4'b0011);
            chk("wr_m1_wait", m1_waitrequest, s_waitrequest);
        end
        cyc(); m1_write = 1'b0; mid();
        chk("wr_idle", {busy, grant}, 3'b000);

        // m0 read+write together: write wins
        cyc();
        m0_read = 1'b1; m0_write = 1'b1; m0_address = 32'h0000_0040; m0_writedata = 32'h0BAD_F00D;
        m0_byteenable = 4'hF;
        mid();
        cyc(); mid();
        chk("rw_only_write", {grant, s_write, s_read}, 4'b0110);
        cyc(); m0_read = 1'b0; m0_write = 1'b0; mid();
        chk("rw_idle", {busy, m0_readdatavalid}, 2'b00);
        repeat (RL + 2) cyc();

        // m0 drops read during OWN; pending m1 then served
        s_waitrequest = 1'b1;
        m0_read = 1'b1; m0_address = 32'h0000_0080;
        mid();
        cyc(); m1_write = 1'b1; m1_address = 32'h0000_00C0; m1_writedata = 32'h1111_2222;
        m1_byteenable = 4'b1100;
        mid();
        chk("drop_own", {grant, s_read, m1_waitrequest}, 4'b0111);
        cyc(); m0_read = 1'b0; mid();
        chk("drop_owner_gone", {grant, s_read, busy}, 4'b0101);
        cyc(); mid();
        chk("drop_idle", {busy, grant, m1_waitrequest}, 4'b0001);
        cyc(); s_waitrequest = 1'b0; mid();
        chk("drop_m1_granted", {grant, s_write}, 3'b101);
        chk("drop_m1_addr", s_address, 32'h0000_00C0);
        cyc(); m1_write = 1'b0; mid();
        chk("drop_m1_done", {busy, grant}, 3'b000);

        // Reset during RDATA
        cyc();
        m0_read = 1'b1; m0_address = 32'h0000_0100;
        mid();
        cyc(); mid();
        cyc(); m0_read = 1'b0; reset = 1'b1; mid();
        chk("rstrd_in_rdata", busy, 1'b1);
        cyc(); reset = 1'b0; mid();
        chk("rstrd_idle", {busy, grant, m0_waitrequest, m1_waitrequest}, 5'b00011);
        chk("rstrd_no_rdv", {m0_readdatavalid, m1_readdatavalid}, 2'b00);
        cyc(); mid();
        chk("rstrd_no_rdv2", {m0_readdatavalid, m1_readdatavalid}, 2'b00);

        // Both masters read continuously for 4 transfers
        cyc();
`ifdef ARB_ROUND_ROBIN_EN
        exp_grant_q = '{2'b01, 2'b10, 2'b01, 2'b10};
        repeat (2) exp_q0.push_back(slv_data(32'h0000_0100));
        repeat (2) exp_q1.push_back(slv_data(32'h0000_0200));
`else
        exp_grant_q = '{2'b01, 2'b01, 2'b01, 2'b01};
        repeat (4) exp_q0.push_back(slv_data(32'h0000_0100));
`endif
        m0_read = 1'b1; m0_address = 32'h0000_0100;
        m1_read = 1'b1; m1_address = 32'h0000_0200;
        for (int t = 0; t < 4; t++) begin
            n = 0;
            mid();
            while (!(s_read && !s_waitrequest) && n < 40) begin
                cyc(); mid(); n++;
            end
            if (n >= 40) chk("rr_timeout", 0, 1);
            else chk("rr_grant", grant, exp_grant_q.pop_front());
            cyc();
        end
        m0_read = 1'b0; m1_read = 1'b0;
        repeat (RL + 4) cyc();
        mid();
        chk("rr_idle", {busy, grant}, 3'b000);
        chk("sb_m0_drained", exp_q0.size(), 0);
        chk("sb_m1_drained", exp_q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_bus_arbiter.md
# mips_bus_arbiter

Two-master arbiter that shares the single Avalon-style memory bus of the MIPS system between master 0 (instruction fetch) and master 1 (data port / loader). It sits between the masters and the RAM slave, grants one master at a time, and forwards that master's signals to the slave. It holds the grant until the transfer is accepted and, for reads, until the read data has been returned to the master that issued the read.

## Interface
- `READ_LATENCY`, default 1: cycles from slave acceptance (read high, `s_waitrequest` low) to valid `s_readdata`; range 1–7.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `m0_address`, `m1_address` in 32: master byte address.
- `m0_read`, `m1_read`, `m0_write`, `m1_write` in 1: master request strobes.
- `m0_writedata`, `m1_writedata` in 32: master write data.
- `m0_byteenable`, `m1_byteenable` in 4: master byte lanes.
- `m0_waitrequest`, `m1_waitrequest` out 1: stall back to the master.
- `m0_readdata`, `m1_readdata` out 32: read data to the master.
- `m0_readdatavalid`, `m1_readdatavalid` out 1: one-cycle read-data strobe.
- `s_address` out 32, `s_read` out 1, `s_write` out 1, `s_writedata` out 32, `s_byteenable` out 4: slave side.
- `s_waitrequest` in 1, `s_readdata` in 32: from the slave.
- `grant` out 2: one-hot owner (bit 0 = m0), `00` when idle.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States:
  - IDLE: nothing driven to the slave; wait for a request.
  - OWN: forward the owner's signals to the slave.
  - RDATA: wait for the read data of an accepted read.
- IDLE:
  - A request is `mX_read | mX_write`.
  - If any master requests, pick a winner, register it into `grant`, and go to OWN.
  - Tie-break follows the Configuration section.
- OWN:
  - The slave outputs are a combinational mux of the owner's inputs.
  - `owner_waitrequest = s_waitrequest`. The non-owner's waitrequest is held at 1.
  - Write accepted (`s_write & !s_waitrequest`): go to IDLE.
  - Read accepted: go to RDATA and load the latency counter with `READ_LATENCY-1`.
  - If the owner drops both strobes before acceptance, return to IDLE. No transfer takes place.
- If a master asserts read and write together, write wins. `s_read` is driven 0.
- RDATA:
  - Slave strobes are 0.
  - The counter decrements each cycle.
  - When the counter is 0, `s_readdata` is copied to the owner's readdata and `readdatavalid` pulses for one cycle. Then go to IDLE.
- `mX_readdata` holds its last value between reads.
- Masters must hold address, data and strobes stable while their waitrequest is high.

## Timing
- Reset values:
  - State IDLE, `grant=00`, `busy=0`.
  - `s_read=0`, `s_write=0`, `s_address=0`, `s_writedata=0`, `s_byteenable=0`.
  - `m0_waitrequest=1`, `m1_waitrequest=1`.
  - `mX_readdatavalid=0`, `mX_readdata=0`.
  - Round-robin pointer = m1 (so m0 wins the first tie).
- Arbitration costs exactly 1 cycle:
  - A request seen in IDLE at edge N appears on the slave in cycle N+1.
  - Waitrequest to the requester stays high through the arbitration cycle.
- Zero-wait write: request at cycle 0, slave strobe and acceptance in cycle 1, IDLE in cycle 2. Minimum write occupancy is 2 cycles.
- Read:
  - Acceptance in cycle 1.
  - `readdatavalid` in cycle 1+`READ_LATENCY`.
  - IDLE in the following cycle.
- Back-to-back requests from the same master always pass through IDLE. No grant is pipelined.
- Reset asserted in any state forces IDLE at the next edge:
  - An outstanding read is discarded and no `readdatavalid` is issued.
  - The pointer is reinitialised.
- A non-owner's request arriving during OWN or RDATA waits. It is arbitrated at the next IDLE.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: on a tie in IDLE, the master not granted last wins. The pointer updates on every grant.
- `ARB_ROUND_ROBIN_EN` undefined:
  - m0 always wins ties. No pointer register exists.
  - m1 is served only when m0 is not requesting in IDLE.

## Test plan
- Reset mid-read (`READ_LATENCY=2`):
  - Stimulus: assert reset while in RDATA.
  - Required: next cycle `busy=0`, `grant=00`, both waitrequest=1, no `readdatavalid` pulse.
- m0 read of 0xBFC00000, slave returns 0x12345678 with `READ_LATENCY=1`, zero wait:
  - `grant=01` in cycle 1, `s_read=1` in cycle 1.
  - `m0_readdatavalid=1` with `m0_readdata=0x12345678` in cycle 2.
  - m1 outputs unchanged.
- m1 write of 0xDEADBEEF to 0xBFC00004 with byteenable 0011, slave waitrequest high for 3 cycles:
  - `s_write` is held with stable address, data and byteenable for 4 cycles.
  - `m1_waitrequest` follows `s_waitrequest` throughout.
  - IDLE one cycle after acceptance.
- Both masters request reads continuously for 4 transfers:
  - With `ARB_ROUND_ROBIN_EN`: grants 01,10,01,10.
  - Without it: grants 01,01,01,01 and m1 is never granted.
- m0 asserts read and write together:
  - Only `s_write=1` is seen.
  - No `m0_readdatavalid` pulse.
- m0 drops read in OWN while `s_waitrequest=1`:
  - Arbiter returns to IDLE.
  - A pending m1 request is granted on the following edge.
